// File: rtl/sha3_pad_stream.sv
// SHA3 input stage: turns a little-endian 64-bit word stream into rate-sized lane blocks
// with pad10*1 padding (domain byte + end marker) and valid/ready flow control on both sides.
module sha3_pad_stream #(
    parameter int          LANE_W    = 64,
    parameter int          MAX_LANES = 18,
    parameter logic [7:0]  DOMAIN    = 8'h06,
    parameter logic [7:0]  PAD_END   = 8'h80
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANE_W-1:0] in_data,
    input  logic              in_last,
    input  logic [3:0]        in_nbytes,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_lane,
    output logic [4:0]        out_lane_idx,
    output logic              out_block_last,
    output logic              out_msg_last,
    output logic              busy,
    output logic              msg_done
);

    localparam int CNT_W = $clog2(MAX_LANES);
    localparam int NB    = LANE_W / 8;

    typedef enum logic [1:0] {IDLE, DATA, FILL, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ov_q, ov_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               bl_q, bl_d;
    logic               ml_q, ml_d;

    logic               out_free;
    logic               at_last;
    logic [CNT_W-1:0]   cnt_next;

    function automatic logic [CNT_W-1:0] rate_last(input logic [1:0] m);
        logic [CNT_W-1:0] r;
        case (m)
            2'd0:    r = CNT_W'(17);
            2'd1:    r = CNT_W'(16);
            2'd2:    r = CNT_W'(12);
            default: r = CNT_W'(8);
        endcase
        return r;
    endfunction

    // Keeps bytes below n, puts DOMAIN at byte n, and closes the block if this is its last lane.
    function automatic logic [LANE_W-1:0] pad_final(input logic [LANE_W-1:0] data,
                                                    input logic [3:0] nb,
                                                    input logic blk_end);
        logic [LANE_W-1:0] r;
        int n;
        n = (nb > 4'(NB)) ? NB : int'(nb);
        r = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < n)
                r[8*i +: 8] = data[8*i +: 8];
            else if (i == n)
                r[8*i +: 8] = DOMAIN;
        end
        if (n != NB && blk_end)
            r[LANE_W-1 -: 8] = r[LANE_W-1 -: 8] ^ PAD_END;
        return r;
    endfunction

    function automatic logic [LANE_W-1:0] fill_lane(input logic pend, input logic blk_end);
        logic [LANE_W-1:0] r;
        r = '0;
        if (pend)
            r[7:0] = DOMAIN;
        if (blk_end)
            r[LANE_W-1 -: 8] = r[LANE_W-1 -: 8] ^ PAD_END;
        return r;
    endfunction

    assign out_free = !ov_q || out_ready;
    assign at_last  = (cnt_q == last_q);
    assign cnt_next = at_last ? '0 : cnt_q + CNT_W'(1);
    assign in_ready = (state_q == DATA) && out_free;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ov_d    = ov_q;
        lane_d  = lane_q;
        idx_d   = idx_q;
        bl_d    = bl_q;
        ml_d    = ml_q;

        if (ov_q && out_ready)
            ov_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    last_d  = rate_last(mode);
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (in_valid && out_free) begin
                    ov_d   = 1'b1;
                    idx_d  = cnt_q;
                    bl_d   = at_last;
                    ml_d   = 1'b0;
                    cnt_d  = cnt_next;
                    lane_d = in_data;
                    if (in_last) begin
                        lane_d = pad_final(in_data, in_nbytes, at_last);
                        if (in_nbytes >= 4'd8) begin
                            // Full final word: padding moves into the following lane(s).
                            pend_d  = 1'b1;
                            state_d = FILL;
                        end else if (at_last) begin
                            ml_d    = 1'b1;
                            state_d = DRAIN;
                        end else begin
                            state_d = FILL;
                        end
                    end
                end
            end
            FILL: begin
                if (out_free) begin
                    ov_d   = 1'b1;
                    idx_d  = cnt_q;
                    bl_d   = at_last;
                    ml_d   = at_last;
                    lane_d = fill_lane(pend_q, at_last);
                    pend_d = 1'b0;
                    cnt_d  = cnt_next;
                    if (at_last)
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (ov_q && out_ready && ml_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    bl_d    = 1'b0;
                    ml_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ov_q    <= 1'b0;
            lane_q  <= '0;
            idx_q   <= '0;
            bl_q    <= 1'b0;
            ml_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ov_q    <= ov_d;
            lane_q  <= lane_d;
            idx_q   <= idx_d;
            bl_q    <= bl_d;
            ml_q    <= ml_d;
        end
    end

    assign out_valid      = ov_q;
    assign out_lane       = lane_q;
    assign out_lane_idx   = 5'(idx_q);
    assign out_block_last = bl_q;
    assign out_msg_last   = ml_q;
    assign busy           = busy_q;
    assign msg_done       = done_q;

endmodule

// File: tb/tb_sha3_pad_stream.sv
// Directed bench for sha3_pad_stream: hand-computed lane sequences for each mode and padding case.
module tb_sha3_pad_stream;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_last;
    logic [3:0]  in_nbytes;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_lane;
    logic [4:0]  out_lane_idx;
    logic        out_block_last;
    logic        out_msg_last;
    logic        busy;
    logic        msg_done;

    always #5 clk = ~clk;

    sha3_pad_stream dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .mode           (mode),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_last        (in_last),
        .in_nbytes      (in_nbytes),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_lane       (out_lane),
        .out_lane_idx   (out_lane_idx),
        .out_block_last (out_block_last),
        .out_msg_last   (out_msg_last),
        .busy           (busy),
        .msg_done       (msg_done)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [63:0] words [64];
    logic [63:0] q_lane [$];
    logic [6:0]  q_tag  [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [63:0] l, input int idx, input bit bl, input bit ml);
        q_lane.push_back(l);
        q_tag.push_back({5'(idx), bl, ml});
    endtask

    task automatic push_zeros(input int from, input int to);
        for (int k = from; k <= to; k++) push(64'h0, k, 1'b0, 1'b0);
    endtask

    task automatic set_word(input int i, input int nw, input logic [3:0] nb_last);
        in_data   = words[i];
        in_last   = (i == nw - 1);
        in_nbytes = (i == nw - 1) ? nb_last : 4'd8;
    endtask

    task automatic drive(input int nw, input logic [3:0] nb_last);
        int i;
        int guard;
        bit acc;
        i = 0;
        guard = 0;
        set_word(0, nw, nb_last);
        in_valid = 1'b1;
        while (i < nw && guard < 4000) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                i++;
                if (i < nw) set_word(i, nw, nb_last);
            end
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (i < nw) chk("drive_timeout", 64'(i), 64'(nw));
    endtask

    task automatic collect(input bit rnd);
        int guard;
        bit held;
        logic [63:0] hl;
        logic [63:0] el;
        logic [6:0]  et;
        guard = 0;
        held  = 1'b0;
        hl    = '0;
        while (q_lane.size() > 0 && guard < 4000) begin
            @(posedge clk); #1;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (held) begin
                chk("hold_lane", out_lane, hl);
                chk("hold_valid", 64'(out_valid), 64'd1);
            end
            held = out_valid && !out_ready;
            hl   = out_lane;
            if (out_valid && out_ready) begin
                el = q_lane.pop_front();
                et = q_tag.pop_front();
                chk("lane", out_lane, el);
                chk("idx_bl_ml", 64'({out_lane_idx, out_block_last, out_msg_last}), 64'(et));
                if (et[0]) chk("msg_done_early", 64'(msg_done), 64'd0);
            end
            guard++;
        end
        if (q_lane.size() > 0) begin
            chk("collect_timeout", 64'(q_lane.size()), 64'd0);
            q_lane.delete();
            q_tag.delete();
        end else begin
            @(negedge clk);
            chk("msg_done", 64'(msg_done), 64'd1);
            chk("busy_end", 64'(busy), 64'd0);
            @(negedge clk);
            chk("msg_done_pulse", 64'(msg_done), 64'd0);
            chk("out_valid_end", 64'(out_valid), 64'd0);
        end
    endtask

    task automatic send_start(input logic [1:0] m);
        @(posedge clk); #1;
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_msg(input logic [1:0] m, input int nw, input logic [3:0] nb,
                           input bit rnd, input bit poke);
        send_start(m);
        if (poke) begin
            // A second start while busy must not change the rate.
            start = 1'b1;
            mode  = 2'd0;
            @(posedge clk); #1;
            start = 1'b0;
        end
        fork
            drive(nw, nb);
            collect(rnd);
        join
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int guard;
        reset_n   = 1'b0;
        start     = 1'b0;
        mode      = 2'd0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_nbytes = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_msg_done", 64'(msg_done), 64'd0);
        chk("rst_out_lane", out_lane, 64'd0);

        // Mode 1, empty final word.
        words[0] = 64'hDEADBEEFCAFEF00D;
        push(64'h0000000000000006, 0, 1'b0, 1'b0);
        push_zeros(1, 15);
        push(64'h8000000000000000, 16, 1'b1, 1'b1);
        run_msg(2'd1, 1, 4'd0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a mode-1 message.
        send_start(2'd1);
        in_valid  = 1'b1;
        in_last   = 1'b0;
        in_nbytes = 4'd8;
        in_data   = 64'h5555AAAA5555AAAA;
        out_ready = 1'b1;
        guard = 0;
        while (!(out_valid && out_lane_idx == 5'd5) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_mid_reach_idx", 64'(out_lane_idx), 64'd5);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mid_no_done", 64'(msg_done), 64'd0);

        // Mode 3, "abc".
        words[0] = 64'h0000000000636261;
        push(64'h0000000006636261, 0, 1'b0, 1'b0);
        push_zeros(1, 7);
        push(64'h8000000000000000, 8, 1'b1, 1'b1);
        run_msg(2'd3, 1, 4'd3, 1'b0, 1'b0);

        // Mode 3, nine full words: one extra padding-only block.
        for (int i = 0; i < 9; i++) begin
            words[i] = {8'hD0 + 8'(i), 56'h0123456789ABCD};
            push(words[i], i, (i == 8), 1'b0);
        end
        push(64'h0000000000000006, 0, 1'b0, 1'b0);
        push_zeros(1, 7);
        push(64'h8000000000000000, 8, 1'b1, 1'b1);
        run_msg(2'd3, 9, 4'd8, 1'b0, 1'b1);

        // Mode 2, final word with 7 bytes lands on lane 12.
        for (int i = 0; i < 12; i++) begin
            words[i] = {8'hB0 + 8'(i), 56'h13579BDF02468A};
            push(words[i], i, 1'b0, 1'b0);
        end
        words[12] = 64'h00AABBCCDDEEFF11;
        push(64'h86AABBCCDDEEFF11, 12, 1'b1, 1'b1);
        run_msg(2'd2, 13, 4'd7, 1'b0, 1'b0);

        // Mode 1, upper bytes of a short final word are discarded.
        words[0] = 64'hFFFFFFFFFF636261;
        push(64'h0000000006636261, 0, 1'b0, 1'b0);
        push_zeros(1, 15);
        push(64'h8000000000000000, 16, 1'b1, 1'b1);
        run_msg(2'd1, 1, 4'd3, 1'b0, 1'b0);

        // Mode 0, in_nbytes above 8 behaves as a full word.
        words[0] = 64'hFFEEDDCCBBAA9988;
        push(64'hFFEEDDCCBBAA9988, 0, 1'b0, 1'b0);
        push(64'h0000000000000006, 1, 1'b0, 1'b0);
        push_zeros(2, 16);
        push(64'h8000000000000000, 17, 1'b1, 1'b1);
        run_msg(2'd0, 1, 4'd15, 1'b0, 1'b0);

        // Mode 3, eight full words: domain and end marker share lane 8.
        for (int i = 0; i < 8; i++) begin
            words[i] = {8'h70 + 8'(i), 56'hFEDCBA98765432};
            push(words[i], i, 1'b0, 1'b0);
        end
        push(64'h8000000000000006, 8, 1'b1, 1'b1);
        run_msg(2'd3, 8, 4'd8, 1'b0, 1'b0);

        // Mode 0, 40 full words with random backpressure.
        for (int i = 0; i < 40; i++) begin
            words[i] = {16'hC0DE, 16'(i), 32'h89ABCD00 | 32'(i)};
            push(words[i], i % 18, ((i % 18) == 17), 1'b0);
        end
        push(64'h0000000000000006, 4, 1'b0, 1'b0);
        push_zeros(5, 16);
        push(64'h8000000000000000, 17, 1'b1, 1'b1);
        run_msg(2'd0, 40, 4'd8, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
